// File: rtl/eth_phy_10g_rx_gearbox_pkg.sv
// Shared 10GBASE-R PCS constants and helpers used by the RX gearbox.
package eth_10g_pkg;

  localparam int          BLOCK_WIDTH       = 66;
  localparam logic [1:0]  SYNC_DATA         = 2'b10;
  localparam logic [1:0]  SYNC_CTRL         = 2'b01;
  localparam int          GEARBOX_BUF_WIDTH = 97;

  function automatic logic [31:0] bit_reverse_32(input logic [31:0] d);
    logic [31:0] r;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = d[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_phy_10g_rx_gearbox_if.sv
// Transceiver-side word input and PCS-side block output of the RX gearbox.
interface eth_phy_10g_rx_gearbox_if #(
  parameter int INPUT_WIDTH = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 2
);
  logic [INPUT_WIDTH-1:0] gt_rx_data;
  logic                   gt_rx_valid;
  logic [DATA_WIDTH-1:0]  serdes_rx_data;
  logic [HDR_WIDTH-1:0]   serdes_rx_hdr;
  logic                   serdes_rx_valid;
  logic                   serdes_rx_bitslip;

  modport master (
    output gt_rx_data, gt_rx_valid, serdes_rx_bitslip,
    input  serdes_rx_data, serdes_rx_hdr, serdes_rx_valid
  );

  modport slave (
    input  gt_rx_data, gt_rx_valid, serdes_rx_bitslip,
    output serdes_rx_data, serdes_rx_hdr, serdes_rx_valid
  );
endinterface

// File: rtl/eth_phy_10g_rx_gearbox.sv
// 32:66 receive gearbox: packs raw transceiver words into 66-bit sync-header
// blocks and discards single bits on bitslip requests from block lock.
module eth_phy_10g_rx_gearbox
  import eth_10g_pkg::*;
#(
  parameter int INPUT_WIDTH = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int HDR_WIDTH   = 2,
  parameter int BIT_REVERSE = 0
) (
  input logic                    clk,
  input logic                    rst,
  eth_phy_10g_rx_gearbox_if.slave bus
);

  if (INPUT_WIDTH != 32) begin : g_bad_input_width
    $error("eth_phy_10g_rx_gearbox: only INPUT_WIDTH=32 is supported");
  end
  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("eth_phy_10g_rx_gearbox: only DATA_WIDTH=64 is supported");
  end
  if (HDR_WIDTH != DATA_WIDTH / 32) begin : g_bad_hdr_width
    $error("eth_phy_10g_rx_gearbox: HDR_WIDTH must equal DATA_WIDTH/32");
  end

  logic [GEARBOX_BUF_WIDTH-1:0] shift_buf_q, shift_buf_n;
  logic [6:0]                   cnt_q, avail;
  logic                         slip_pend_q, slip_pend_n;
  logic                         slip;
  logic                         emit;
  logic [BLOCK_WIDTH-1:0]       blk;
  logic [INPUT_WIDTH-1:0]       word;

  logic [DATA_WIDTH-1:0]        data_q;
  logic [HDR_WIDTH-1:0]         hdr_q;
  logic                         valid_q;

  assign word = (BIT_REVERSE != 0) ? bit_reverse_32(bus.gt_rx_data) : bus.gt_rx_data;

  // Append, extract a block, then slip: a slip always removes the oldest
  // bit still buffered after any block has been taken out this cycle.
  always_comb begin
    shift_buf_n = shift_buf_q;
    avail       = cnt_q;
    slip_pend_n = slip_pend_q;
    emit        = 1'b0;
    blk         = '0;

    if (bus.gt_rx_valid) begin
      shift_buf_n = shift_buf_n
                  | ({{(GEARBOX_BUF_WIDTH-INPUT_WIDTH){1'b0}}, word} << cnt_q);
      avail       = cnt_q + 7'd32;
    end

    if (avail >= 7'd66) begin
      emit        = 1'b1;
      blk         = shift_buf_n[BLOCK_WIDTH-1:0];
      shift_buf_n = shift_buf_n >> BLOCK_WIDTH;
      avail       = avail - 7'd66;
    end

    slip = bus.serdes_rx_bitslip | slip_pend_q;
    if (slip) begin
      if (avail != 7'd0) begin
        shift_buf_n = shift_buf_n >> 1;
        avail       = avail - 7'd1;
        slip_pend_n = 1'b0;
      end else begin
        slip_pend_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_buf_q <= '0;
      cnt_q       <= '0;
      slip_pend_q <= 1'b0;
      data_q      <= '0;
      hdr_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      shift_buf_q <= shift_buf_n;
      cnt_q       <= avail;
      slip_pend_q <= slip_pend_n;
      valid_q     <= emit;
      if (emit) begin
        hdr_q  <= blk[HDR_WIDTH-1:0];
        data_q <= blk[HDR_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.serdes_rx_data  = data_q;
  assign bus.serdes_rx_hdr   = hdr_q;
  assign bus.serdes_rx_valid = valid_q;

endmodule

// File: tb/tb_eth_phy_10g_rx_gearbox.sv
// Scoreboard bench for the RX gearbox: a bit-queue reference model predicts
// each 66-bit block when words are driven; monitors compare DUT output blocks.
module tb_eth_phy_10g_rx_gearbox;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_phy_10g_rx_gearbox_if bus0 ();
  eth_phy_10g_rx_gearbox_if bus1 ();

  eth_phy_10g_rx_gearbox #(.BIT_REVERSE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  eth_phy_10g_rx_gearbox #(.BIT_REVERSE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_checks = 0;
  int n_fail   = 0;

  logic        stream[$];
  logic        mbits[$];
  logic        mpend;
  logic [65:0] exp0[$];
  logic [65:0] exp1[$];

  int          nw;
  int          nobs;
  int          first_nw;
  logic [1:0]  obs_hdr[64];
  logic [63:0] obs_data[64];
  logic        prev_v0 = 1'b0;
  logic        prev_v1 = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = d[31-i];
    return r;
  endfunction

  // Stream: `offset` junk ones, then 16 blocks with alternating headers
  // 01/10 and payload = block index replicated in every byte.
  task automatic build_stream(input int offset);
    logic [7:0]  ib;
    logic [1:0]  h;
    logic [63:0] d;
    stream.delete();
    for (int i = 0; i < offset; i++) stream.push_back(1'b1);
    for (int b = 0; b < 16; b++) begin
      ib = 8'(b);
      h  = (b % 2 == 0) ? 2'b01 : 2'b10;
      d  = {8{ib}};
      for (int j = 0; j < 2; j++)  stream.push_back(h[j]);
      for (int j = 0; j < 64; j++) stream.push_back(d[j]);
    end
  endtask

  function automatic logic [31:0] word_at(input int k);
    logic [31:0] w;
    for (int j = 0; j < 32; j++) begin
      w[j] = (32*k + j < stream.size()) ? stream[32*k + j] : 1'b0;
    end
    return w;
  endfunction

  task automatic drive(input logic [31:0] w, input logic v, input logic s, input int tgt);
    logic [65:0] blk;
    if (v) for (int j = 0; j < 32; j++) mbits.push_back(w[j]);
    if (mbits.size() >= 66) begin
      for (int j = 0; j < 66; j++) blk[j] = mbits.pop_front();
      if (tgt == 0) exp0.push_back(blk);
      else          exp1.push_back(blk);
    end
    if (s || mpend) begin
      if (mbits.size() >= 1) begin
        void'(mbits.pop_front());
        mpend = 1'b0;
      end else begin
        mpend = 1'b1;
      end
    end
    bus0.gt_rx_data        = (tgt == 0) ? w : 32'h0;
    bus0.gt_rx_valid       = (tgt == 0) ? v : 1'b0;
    bus0.serdes_rx_bitslip = (tgt == 0) ? s : 1'b0;
    bus1.gt_rx_data        = (tgt == 1) ? rev32(w) : 32'h0;
    bus1.gt_rx_valid       = (tgt == 1) ? v : 1'b0;
    bus1.serdes_rx_bitslip = (tgt == 1) ? s : 1'b0;
    @(posedge clk); #1;
    nw++;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    bus0.gt_rx_valid = 1'b0; bus0.serdes_rx_bitslip = 1'b0; bus0.gt_rx_data = '0;
    bus1.gt_rx_valid = 1'b0; bus1.serdes_rx_bitslip = 1'b0; bus1.gt_rx_data = '0;
    repeat (cycles) begin @(posedge clk); #1; end
    check_eq("rst_valid0", bus0.serdes_rx_valid, 0);
    check_eq("rst_data0",  bus0.serdes_rx_data,  0);
    check_eq("rst_hdr0",   bus0.serdes_rx_hdr,   0);
    check_eq("rst_valid1", bus1.serdes_rx_valid, 0);
    rst = 1'b0;
    mbits.delete();
    mpend = 1'b0;
    exp0.delete();
    exp1.delete();
    nw = 0;
    nobs = 0;
    first_nw = -1;
  endtask

  task automatic drain(input int tgt, input string tag);
    repeat (3) drive(32'h0, 1'b0, 1'b0, tgt);
    check_eq({tag, "_exp0_empty"}, exp0.size(), 0);
    check_eq({tag, "_exp1_empty"}, exp1.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [65:0] e;
    if (bus0.serdes_rx_valid) begin
      check_eq("no_b2b0", prev_v0, 0);
      if (exp0.size() == 0) check_eq("extra_blk0", exp0.size(), 1);
      else begin
        e = exp0.pop_front();
        check_eq("hdr0",  bus0.serdes_rx_hdr,  e[1:0]);
        check_eq("data0", bus0.serdes_rx_data, e[65:2]);
      end
      if (nobs < 64) begin
        obs_hdr[nobs]  = bus0.serdes_rx_hdr;
        obs_data[nobs] = bus0.serdes_rx_data;
      end
      if (nobs == 0) first_nw = nw;
      nobs++;
    end
    if (bus1.serdes_rx_valid) begin
      check_eq("no_b2b1", prev_v1, 0);
      if (exp1.size() == 0) check_eq("extra_blk1", exp1.size(), 1);
      else begin
        e = exp1.pop_front();
        check_eq("hdr1",  bus1.serdes_rx_hdr,  e[1:0]);
        check_eq("data1", bus1.serdes_rx_data, e[65:2]);
      end
      if (nobs < 64) begin
        obs_hdr[nobs]  = bus1.serdes_rx_hdr;
        obs_data[nobs] = bus1.serdes_rx_data;
      end
      if (nobs == 0) first_nw = nw;
      nobs++;
    end
    prev_v0 = bus0.serdes_rx_valid;
    prev_v1 = bus1.serdes_rx_valid;
  end

  initial begin
    int k;
    int guard;
    mpend = 1'b0;
    nw = 0;
    nobs = 0;
    first_nw = -1;

    // Aligned stream
    do_reset(2);
    build_stream(0);
    for (int i = 0; i < 33; i++) drive(word_at(i), 1'b1, 1'b0, 0);
    drain(0, "aligned");
    check_eq("aligned_count", nobs, 16);
    check_eq("aligned_first_valid_word", first_nw, 3);
    check_eq("aligned_blk0_hdr", obs_hdr[0], 2'b01);
    check_eq("aligned_blk15_data", obs_data[15], {8{8'd15}});
    check_eq("hold_data", bus0.serdes_rx_data, {8{8'd15}});
    check_eq("hold_hdr",  bus0.serdes_rx_hdr,  2'b10);

    // Stream offset by 5 bits, realigned by 5 isolated slip pulses
    do_reset(1);
    build_stream(5);
    for (int i = 0; i < 36; i++) begin
      drive(word_at(i), 1'b1, (i >= 6 && i <= 14 && i % 2 == 0), 0);
    end
    drain(0, "bitslip");
    check_eq("slip_pre_hdr_misaligned", obs_hdr[0], 2'b11);
    check_eq("slip_blk14_hdr", obs_hdr[14], 2'b01);
    check_eq("slip_blk15_hdr", obs_hdr[15], 2'b10);
    check_eq("slip_blk15_data", obs_data[15], {8{8'd15}});

    // Input gaps every third cycle
    do_reset(1);
    build_stream(0);
    k = 0;
    for (int c = 0; k < 33 && c < 200; c++) begin
      if (c % 3 == 2) drive(32'h0, 1'b0, 1'b0, 0);
      else begin
        drive(word_at(k), 1'b1, 1'b0, 0);
        k++;
      end
    end
    drain(0, "gaps");
    check_eq("gaps_count", nobs, 16);
    check_eq("gaps_blk7_data", obs_data[7], {8{8'd7}});

    // Deferred slip straight after reset
    do_reset(1);
    build_stream(0);
    drive(32'h0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 33; i++) drive(word_at(i), 1'b1, 1'b0, 0);
    drain(0, "deferred");
    check_eq("deferred_blk0_hdr", obs_hdr[0], 2'b00);

    // Reset with 40 bits buffered
    do_reset(1);
    build_stream(0);
    guard = 0;
    while (mbits.size() != 40 && guard < 60) begin
      drive(32'hA5C3_0F96 ^ 32'(guard), 1'b1, 1'b0, 0);
      guard++;
    end
    check_eq("midrst_cnt40", mbits.size(), 40);
    check_eq("midrst_exp_empty", exp0.size(), 0);
    do_reset(1);
    for (int i = 0; i < 33; i++) drive(word_at(i), 1'b1, 1'b0, 0);
    drain(0, "midrst");
    check_eq("midrst_count", nobs, 16);
    check_eq("midrst_blk0_hdr", obs_hdr[0], 2'b01);
    check_eq("midrst_blk0_data", obs_data[0], 64'h0);

    // Bit-reversed input on the BIT_REVERSE=1 instance
    do_reset(1);
    build_stream(0);
    for (int i = 0; i < 33; i++) drive(word_at(i), 1'b1, 1'b0, 1);
    drain(1, "reverse");
    check_eq("reverse_count", nobs, 16);
    check_eq("reverse_blk1_hdr", obs_hdr[1], 2'b10);
    check_eq("reverse_blk9_data", obs_data[9], {8{8'd9}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eth_phy_10g_rx_gearbox.md
Name: eth_phy_10g_rx_gearbox

Overview:
- 32:66 receive gearbox feeding the 10GBASE-R RX PHY path.
- Accepts raw 32-bit transceiver words and emits 66-bit blocks: 2-bit sync header plus 64-bit payload.
- Qualifies each block with a valid strobe.
- Implements the bitslip requested by the downstream block-lock logic by discarding single bits from the stream.

Parameters:
- INPUT_WIDTH, 32, raw transceiver word width; only 32 supported (elaboration error otherwise).
- DATA_WIDTH, 64, block payload width; only 64 supported.
- HDR_WIDTH, 2, sync header width; must equal DATA_WIDTH/32.
- BIT_REVERSE, 0, 1 = reverse bit order of each input word before gearing.

Ports:
- clk  input  1  clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- gt_rx_data  input  INPUT_WIDTH  raw received word, first-received bit in bit 0 (after optional reversal).
- gt_rx_valid  input  1  gt_rx_data valid this cycle.
- serdes_rx_data  output  DATA_WIDTH  block payload.
- serdes_rx_hdr  output  HDR_WIDTH  sync header.
- serdes_rx_valid  output  1  block valid; one-cycle strobe per block.
- serdes_rx_bitslip  input  1  slip request; each cycle high = discard one bit.

Behaviour:
- State:
  - buf: 97-bit shift buffer, LSB = oldest bit.
  - cnt: 7-bit count of valid bits, 0..65 between cycles.
  - slip_pend: 1-bit deferred slip flag.
- Each cycle, in order:
  - (a) if gt_rx_valid: buf |= word << cnt; avail = cnt+32; else avail = cnt.
  - (b) if avail >= 66: register block, hdr = buf[1:0], data = buf[65:2]; serdes_rx_valid=1 next cycle; buf >>= 66; avail -= 66.
  - (c) slip = serdes_rx_bitslip | slip_pend. If slip and avail >= 1: buf >>= 1, avail -= 1, slip_pend = 0. If slip and avail == 0: slip_pend = 1.
  - (d) cnt = avail.
- Latency: block is presented one cycle after the cycle carrying its final bit.
- Steady state with gt_rx_valid=1: exactly 16 blocks per 33 cycles. Valid never asserts in two consecutive cycles.
- Bitslip back-to-back pulses accumulate: N high cycles = N bits discarded. slip_pend holds at most one deferred slip; a second slip while pend is set and avail==0 is dropped.
- gt_rx_valid low: no bits appended. Pending output still completes if avail >= 66, which cannot occur because cnt <= 65; so no output is produced.
- serdes_rx_data/hdr hold their last value when valid is low.
- Reset values: all outputs 0, buf 0, cnt 0, slip_pend 0.
- Reset asserted mid-block discards all buffered bits. The first output after reset is built from the first 66 bits received after reset.
- Bits are never duplicated or reordered. Header/data bit order matches the descrambler's LSB-first convention.

Decomposition:
- Shared package eth_10g_pkg:
  - BLOCK_WIDTH=66, SYNC_DATA=2'b10, SYNC_CTRL=2'b01.
  - GEARBOX_BUF_WIDTH=97.
  - Function bit_reverse_32.
- No sub-module; single always block plus output registers.
- The bitslip count in step (c) is kept inline.

Test Plan:
- Aligned stream: 33 words carrying 16 blocks, headers alternating 2'b01/2'b10, payload = block index replicated → exactly 16 valid strobes in 33 cycles, data/hdr exact, first valid on cycle 3 after the third word.
- Bitslip: stream pre-offset by 5 bits → after 5 single-cycle bitslip pulses, all subsequent blocks decode with correct headers; before the pulses, headers are mismatched.
- Input gaps: same 16-block payload with gt_rx_valid low on every third cycle → identical 16 blocks in order, none lost or repeated.
- Deferred slip: assert bitslip in the cycle immediately after reset (cnt=0, gt_rx_valid=0) → slip_pend=1; first block emitted is the stream shifted by exactly 1 bit.
- Reset mid-operation: assert rst for 1 cycle with cnt=40 → outputs 0 next cycle; next block is formed from the first 66 bits after reset.
- BIT_REVERSE=1: input words bit-reversed from the scenario-1 stream → identical block sequence to scenario 1.
